class_histogram: RTL and testbench

//  Downstream consumer of the 4-bit wildcard priority classifier. Takes its 2-bit

---
 rtl/hist_pkg.sv | 15 +
 rtl/class_histogram_sat_counter.sv | 55 +++++
 rtl/class_histogram.sv | 110 +++++++++++
 tb/tb_class_histogram.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared definitions for the class histogram and the classifier bench.
package hist_pkg;

  // Drain controller states
  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } hist_state_t;

  // Number of histogram bins for a given class code width
  function automatic int hist_ncls(input int cls_w);
    return 32'sd1 << cls_w;
  endfunction

endpackage

// File: rtl/class_histogram_sat_counter.sv
// One histogram bin: saturating up-counter with a sticky saturation flag.
// Clear wins over increment; the two never coincide in the parent because
// the input is stalled while bins are being drained.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  // Next count: clear, hold at max (flagging saturation), or increment
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr_i) begin
      count_d = {CNT_W{1'b0}};
      sat_d   = 1'b0;
    end else if (inc_i) begin
      if (count_q == MAX_CNT) begin
        count_d = count_q;
        sat_d   = 1'b1;
      end else begin
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        sat_d   = sat_q;
      end
    end else begin
      count_d = count_q;
      sat_d   = sat_q;
    end
  end

  // Bin state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/class_histogram.sv
// Per-class saturating histogram fed by classifier codes; drains all bins in
// index order on request, clearing each bin as its record is consumed.
module class_histogram
  import hist_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int CLS_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CLS_W-1:0] in_cls,
  input  logic             dump_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CLS_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_last,
  output logic             busy
);

  localparam int               NCLS     = hist_ncls(CLS_W);
  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NCLS - 1);

  hist_state_t      state_q, state_d;
  logic [CLS_W-1:0] ptr_q, ptr_d;

  logic [CNT_W-1:0] cnt_s [NCLS];
  logic [NCLS-1:0]  sat_s;
  logic [NCLS-1:0]  inc_s;
  logic [NCLS-1:0]  clr_s;
  logic             accept_s;
  logic             hs_s;
  logic             dumping_s;

  assign dumping_s = (state_q == DUMP);
  assign accept_s  = in_valid && in_ready;
  assign hs_s      = out_valid && out_ready;

  // One saturating counter per bin; increments only in IDLE, clears on read
  for (genvar g = 0; g < NCLS; g++) begin : g_bin
    assign inc_s[g] = accept_s && (in_cls == CLS_W'(g));
    assign clr_s[g] = hs_s && (ptr_q == CLS_W'(g));

    sat_counter #(.CNT_W(CNT_W)) u_bin (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (inc_s[g]),
      .clr_i   (clr_s[g]),
      .count_o (cnt_s[g]),
      .sat_o   (sat_s[g])
    );
  end

  // Next state: start a drain from IDLE, walk bins on each handshake, leave after the last
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d = DUMP;
          ptr_d   = {CLS_W{1'b0}};
        end else begin
          state_d = IDLE;
          ptr_d   = ptr_q;
        end
      end
      DUMP: begin
        if (out_ready && (ptr_q == LAST_IDX)) begin
          state_d = IDLE;
          ptr_d   = {CLS_W{1'b0}};
        end else if (out_ready) begin
          state_d = DUMP;
          ptr_d   = ptr_q + {{(CLS_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = DUMP;
          ptr_d   = ptr_q;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = {CLS_W{1'b0}};
      end
    endcase
  end

  // Controller state and bin pointer with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= {CLS_W{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Outputs are plain muxes of registered state: zero latency from state
  assign in_ready  = !dumping_s;
  assign out_valid = dumping_s;
  assign busy      = dumping_s;
  assign out_idx   = ptr_q;
  assign out_count = cnt_s[ptr_q];
  assign out_sat   = sat_s[ptr_q];
  assign out_last  = dumping_s && (ptr_q == LAST_IDX);

endmodule

// File: tb/tb_class_histogram.sv
// Self-checking bench for class_histogram: directed scenarios with literal
// expectations plus randomized traffic checked against a sample-count model.
module tb_class_histogram;

  localparam int CNT_W = 4;
  localparam int CLS_W = 2;
  localparam int NCLS  = 4;
  localparam int MAXC  = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CLS_W-1:0] in_cls = '0;
  logic             dump_req = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CLS_W-1:0] out_idx;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;
  logic             out_last;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  class_histogram #(.CNT_W(CNT_W), .CLS_W(CLS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cls    (in_cls),
    .dump_req  (dump_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_count (out_count),
    .out_sat   (out_sat),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each bin is just the number of samples accepted since its last drain.
  // A drain snapshots all bins into a queue of records (input is stalled
  // while draining, so the snapshot equals what is read out).
  typedef struct {
    int idx;
    int cnt;
    bit sat;
    bit last;
  } rec_t;

  int   mc [NCLS];
  rec_t rq [$];

  // Compare outputs against the model, then advance the model with the
  // inputs that the coming posedge will sample
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  in_ready,  rq.size() == 0);
      check("out_valid", out_valid, rq.size() != 0);
      check("busy",      busy,      rq.size() != 0);
      if (rq.size() != 0) begin
        check("out_idx",   out_idx,   rq[0].idx);
        check("out_count", out_count, rq[0].cnt);
        check("out_sat",   out_sat,   rq[0].sat);
        check("out_last",  out_last,  rq[0].last);
      end else begin
        check("out_last_idle", out_last, 0);
      end
    end
    if (rst) begin
      for (int i = 0; i < NCLS; i++) mc[i] = 0;
      rq.delete();
    end else if (rq.size() != 0) begin
      if (out_ready) void'(rq.pop_front());
    end else begin
      if (in_valid) mc[in_cls]++;
      if (dump_req) begin
        for (int i = 0; i < NCLS; i++) begin
          rq.push_back('{idx: i, cnt: (mc[i] > MAXC) ? MAXC : mc[i],
                         sat: (mc[i] > MAXC), last: (i == NCLS - 1)});
          mc[i] = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; dump_req = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input int cls, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_cls   = CLS_W'(cls);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Request a drain and collect records; idx order must be 0..NCLS-1
  task automatic drain(input bit toggle, output int cnt [NCLS], output bit sat [NCLS],
                       output int nrec, output int nlast);
    int  cyc;
    bit  done;
    for (int i = 0; i < NCLS; i++) begin cnt[i] = -1; sat[i] = 1'b0; end
    nrec = 0; nlast = 0; cyc = 0; done = 1'b0;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    while (!done && cyc < 40) begin
      out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        check("drain_seq", out_idx, nrec);
        cnt[out_idx] = out_count;
        sat[out_idx] = out_sat;
        if (out_last) begin
          nlast++;
          done = 1'b1;
        end
        nrec++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    if (!done) check("drain_timeout", 0, 1);
  endtask

  int  c [NCLS];
  bit  s [NCLS];
  int  nrec, nlast, drains, gap;

  initial begin
    do_reset();
    chk_en = 1'b1;
    check("reset_in_ready",  in_ready,  1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy",      busy,      0);

    // 1: classes 0,1,1,3,3,3 back to back
    send(0, 1); send(1, 2); send(3, 3);
    drain(1'b0, c, s, nrec, nlast);
    check("t1_b0", c[0], 1); check("t1_b1", c[1], 2);
    check("t1_b2", c[2], 0); check("t1_b3", c[3], 3);
    check("t1_nrec", nrec, 4); check("t1_nlast", nlast, 1);
    tick();
    drain(1'b0, c, s, nrec, nlast);
    for (int i = 0; i < NCLS; i++) check("t1_redump_zero", c[i], 0);

    // 2: saturation of bin 2
    do_reset();
    send(2, 21);
    drain(1'b0, c, s, nrec, nlast);
    check("t2_count", c[2], 15); check("t2_sat", s[2], 1);
    check("t2_b0_sat", s[0], 0);
    tick();
    drain(1'b0, c, s, nrec, nlast);
    check("t2_recount", c[2], 0); check("t2_resat", s[2], 0);

    // 3: sample and dump request in the same cycle
    do_reset();
    in_valid = 1'b1; in_cls = 2'd1; dump_req = 1'b1;
    tick();
    in_valid = 1'b0; dump_req = 1'b0;
    check("t3_stalled", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < NCLS; i++) begin
      if (out_idx == 2'd1) check("t3_bin1", out_count, 1);
      check("t3_in_ready_low", in_ready, 0);
      tick();
    end
    out_ready = 1'b0;
    check("t3_in_ready_back", in_ready, 1);

    // 4: stalled drain with out_ready toggling
    send(0, 2); send(3, 1);
    drain(1'b1, c, s, nrec, nlast);
    check("t4_nrec", nrec, 4); check("t4_nlast", nlast, 1);
    check("t4_b0", c[0], 2); check("t4_b3", c[3], 1);

    // 5: reset in the middle of a drain
    tick();
    send(2, 3); send(1, 1);
    dump_req = 1'b1; tick(); dump_req = 1'b0;
    out_ready = 1'b1; tick(); tick();
    rst = 1'b1; out_ready = 1'b0; tick(); rst = 1'b0;
    check("t5_out_valid", out_valid, 0);
    drain(1'b0, c, s, nrec, nlast);
    for (int i = 0; i < NCLS; i++) check("t5_zero", c[i], 0);

    // 6: dump_req held high for 10 cycles
    tick();
    send(1, 2);
    out_ready = 1'b1;
    drains = 0; gap = 0;
    for (int k = 0; k < 16; k++) begin
      dump_req = (k < 10);
      #1;
      if (out_valid && out_last) drains++;
      if (in_ready && drains == 1) gap++;
      tick();
    end
    dump_req = 1'b0; out_ready = 1'b0;
    check("t6_drains", drains, 2);
    check("t6_gap", gap, 1);

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_cls    = CLS_W'($urandom_range(0, NCLS - 1));
      dump_req  = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; dump_req = 1'b0; out_ready = 1'b1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
